// File: rtl/hopfield_update_ctrl.sv
// Purpose : asynchronous-update controller for a Hopfield network; owns the spin
//           state, evaluates one neuron at a time in index order, repeats sweeps.
// Latency : 2 cycles per neuron with zero-wait ack (REQ + NEXT), 2N per sweep.
// Backpressure: REQ is held until eval_ack; acks outside REQ are dropped.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   load, pattern_in    load probe pattern (only when idle/done)
//   start               begin a recall run (only when idle/done)
//   eval_req/eval_idx   request evaluation of one neuron
//   eval_ack/eval_bit   neuron result (1 = +1, 0 = -1)
//   spin_rd_idx/_word   combinational Q8.8 read of one spin for the neuron stage
//   state_q             current spin state
//   busy, done          run in progress / run finished (level)
//   converged           valid with done; 1 = a sweep produced no change
//   sweep_count         sweeps completed in the current or last run
module hopfield_update_ctrl #(
    parameter int N          = 25,
    parameter int IDXW       = 5,
    parameter int MAX_SWEEPS = 8,
    parameter int SWW        = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [N-1:0]    pattern_in,
    input  logic            start,
    output logic            eval_req,
    output logic [IDXW-1:0] eval_idx,
    input  logic            eval_ack,
    input  logic            eval_bit,
    input  logic [IDXW-1:0] spin_rd_idx,
    output logic [15:0]     spin_rd_word,
    output logic [N-1:0]    state_q,
    output logic            busy,
    output logic            done,
    output logic            converged,
    output logic [SWW-1:0]  sweep_count
);

    typedef enum logic [1:0] {IDLE, REQ, NEXT, DONE} fsm_e;

    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(N - 1);
    localparam logic [SWW-1:0]  SWEEP_LIM = SWW'(MAX_SWEEPS);

    fsm_e            fsm_q, fsm_d;
    logic [N-1:0]    state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [SWW-1:0]  sweep_q, sweep_d;
    logic            chg_q, chg_d;
    logic            conv_q, conv_d;
    logic [SWW-1:0]  sweep_inc;

    assign sweep_inc = sweep_q + 1'b1;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            idx_q   <= '0;
            sweep_q <= '0;
            chg_q   <= 1'b0;
            conv_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            sweep_q <= sweep_d;
            chg_q   <= chg_d;
            conv_q  <= conv_d;
        end
    end

    // Next-state logic
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        idx_d   = idx_q;
        sweep_d = sweep_q;
        chg_d   = chg_q;
        conv_d  = conv_q;
        case (fsm_q)
            IDLE, DONE: begin
                // A load from DONE drops back to IDLE so done clears.
                if (load) begin
                    state_d = pattern_in;
                    conv_d  = 1'b0;
                    fsm_d   = IDLE;
                end
                // start wins the FSM transition; a simultaneous load still
                // lands in state_d, so the run sees the new pattern.
                if (start) begin
                    idx_d   = '0;
                    sweep_d = '0;
                    chg_d   = 1'b0;
                    conv_d  = 1'b0;
                    fsm_d   = REQ;
                end
            end
            REQ: begin
                if (eval_ack) begin
                    state_d[idx_q] = eval_bit;
                    if (eval_bit != state_q[idx_q]) begin
                        chg_d = 1'b1;
                    end
                    fsm_d = NEXT;
                end
            end
            NEXT: begin
                // One idle cycle so the neuron sees the updated spin.
                if (idx_q != LAST_IDX) begin
                    idx_d = idx_q + 1'b1;
                    fsm_d = REQ;
                end else begin
                    sweep_d = sweep_inc;
                    if (!chg_q) begin
                        conv_d = 1'b1;
                        fsm_d  = DONE;
                    end else if (sweep_inc == SWEEP_LIM) begin
                        conv_d = 1'b0;
                        fsm_d  = DONE;
                    end else begin
                        idx_d = '0;
                        chg_d = 1'b0;
                        fsm_d = REQ;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        eval_req     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (fsm_q)
            REQ:     begin eval_req = 1'b1; busy = 1'b1; end
            NEXT:    busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
        eval_idx     = idx_q;
        converged    = conv_q;
        sweep_count  = sweep_q;
        spin_rd_word = 16'h0000;
        if (int'(spin_rd_idx) < N) begin
            spin_rd_word = state_q[spin_rd_idx] ? 16'h0100 : 16'hFF00;
        end
    end

endmodule

// File: tb/tb_hopfield_update_ctrl.sv
module tb_hopfield_update_ctrl;

    localparam int N     = 25;
    localparam int IDXW  = 5;
    localparam int MAXSW = 8;
    localparam int SWW   = 4;

    // Responder modes: what the neuron stage returns for spin i.
    localparam int M_COPY = 0;  // current value -> no change
    localparam int M_ONE  = 1;  // always +1
    localparam int M_INV  = 2;  // opposite of current value

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            load = 1'b0;
    logic [N-1:0]    pattern_in = '0;
    logic            start = 1'b0;
    logic            eval_req;
    logic [IDXW-1:0] eval_idx;
    logic            eval_ack = 1'b0;
    logic            eval_bit = 1'b0;
    logic [IDXW-1:0] spin_rd_idx = '0;
    logic [15:0]     spin_rd_word;
    logic [N-1:0]    state_q;
    logic            busy, done, converged;
    logic [SWW-1:0]  sweep_count;

    hopfield_update_ctrl #(.N(N), .IDXW(IDXW), .MAX_SWEEPS(MAXSW), .SWW(SWW)) dut (
        .clk(clk), .rst(rst), .load(load), .pattern_in(pattern_in), .start(start),
        .eval_req(eval_req), .eval_idx(eval_idx), .eval_ack(eval_ack), .eval_bit(eval_bit),
        .spin_rd_idx(spin_rd_idx), .spin_rd_word(spin_rd_word), .state_q(state_q),
        .busy(busy), .done(done), .converged(converged), .sweep_count(sweep_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit neuron(input int mode, input bit cur);
        case (mode)
            M_ONE:   return 1'b1;
            M_INV:   return ~cur;
            default: return cur;
        endcase
    endfunction

    // Sweep-level model of a full recall run.
    task automatic model_run(input logic [N-1:0] pat, input int mode,
                             output logic [N-1:0] fin, output int sweeps, output bit conv);
        logic [N-1:0] s;
        bit changed;
        bit b;
        s = pat;
        conv = 1'b0;
        sweeps = MAXSW;
        for (int sw = 1; sw <= MAXSW; sw++) begin
            changed = 1'b0;
            for (int i = 0; i < N; i++) begin
                b = neuron(mode, s[i]);
                if (b != s[i]) changed = 1'b1;
                s[i] = b;
            end
            if (!changed) begin
                conv = 1'b1;
                sweeps = sw;
                break;
            end
        end
        fin = s;
    endtask

    // Shared between the stimulus and the compare/responder process.
    logic [N-1:0] m_state   = '0;
    bit           chk_en    = 1'b0;
    bit           stray_en  = 1'b0;
    int           resp_mode = M_COPY;
    int           resp_dly  = 0;
    int           wait_cnt  = 0;
    int           served    = 0;
    int           exp_total = 0;

    // Compare + responder: checks the spin state against the model each
    // cycle, checks the requested index order, and answers requests.
    always @(negedge clk) begin
        bit b;
        eval_ack = 1'b0;
        eval_bit = 1'b0;
        if (chk_en) begin
            chk("state_vs_model", 32'(state_q), 32'(m_state));
            if (eval_req) begin
                if (wait_cnt >= resp_dly) begin
                    chk("eval_idx_order", 32'(eval_idx), 32'(served % N));
                    if (served >= exp_total) chk("req_beyond_model", 32'(served), 32'(exp_total - 1));
                    b = neuron(resp_mode, m_state[served % N]);
                    eval_ack = 1'b1;
                    eval_bit = b;
                    m_state[served % N] = b;
                    served++;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else if (stray_en && busy) begin
                // Ack during NEXT with a bit that would flip the spin.
                eval_ack = 1'b1;
                eval_bit = ~m_state[eval_idx];
            end
        end
    end

    task automatic do_run(input string tag, input logic [N-1:0] pat, input int mode, input int dly,
                          input bit joint, input bit disturb, output int elapsed);
        logic [N-1:0] fin;
        int sw;
        bit cv;
        int t0;
        bit got;
        model_run(pat, mode, fin, sw, cv);
        resp_mode = mode;
        resp_dly  = dly;
        served    = 0;
        wait_cnt  = 0;
        exp_total = sw * N;
        if (!joint) begin
            @(posedge clk); #1 load = 1'b1; pattern_in = pat;
            @(posedge clk); #1 load = 1'b0; m_state = pat;
            chk({tag, "_done_clr_by_load"}, 32'(done), 32'd0);
        end
        @(posedge clk); #1 start = 1'b1;
        if (joint) begin load = 1'b1; pattern_in = pat; end
        @(posedge clk); #1 start = 1'b0; load = 1'b0;
        if (joint) m_state = pat;
        t0 = cyc;
        if (disturb) begin
            repeat (20) @(posedge clk);
            #1 load = 1'b1; start = 1'b1; pattern_in = ~pat;
            @(posedge clk); #1 load = 1'b0; start = 1'b0;
        end
        got = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            if (done) begin got = 1'b1; break; end
        end
        elapsed = cyc - t0;
        chk({tag, "_done"}, 32'(got), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_converged"}, 32'(converged), 32'(cv));
        chk({tag, "_sweep_count"}, 32'(sweep_count), 32'(sw));
        chk({tag, "_state"}, 32'(state_q), 32'(fin));
        chk({tag, "_evals"}, 32'(served), 32'(sw * N));
        if (dly == 0) chk({tag, "_cycles"}, 32'(elapsed), 32'(2 * N * sw));
    endtask

    initial begin
        int el;
        logic [IDXW-1:0] rd_idx [4];
        logic [15:0]     rd_exp [4];
        bit hit;

        // Reset values while rst is asserted.
        #3;
        chk("rst_state", 32'(state_q), 32'd0);
        chk("rst_eval_req", 32'(eval_req), 32'd0);
        chk("rst_eval_idx", 32'(eval_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_conv", 32'(converged), 32'd0);
        chk("rst_sweeps", 32'(sweep_count), 32'd0);
        #9 rst = 1'b1;
        m_state = '0;
        chk_en = 1'b1;

        // Read port on state 25'h0000001.
        @(posedge clk); #1 load = 1'b1; pattern_in = 25'h0000001;
        @(posedge clk); #1 load = 1'b0; m_state = 25'h0000001;
        rd_idx[0] = 5'd0;  rd_exp[0] = 16'h0100;
        rd_idx[1] = 5'd1;  rd_exp[1] = 16'hFF00;
        rd_idx[2] = 5'd25; rd_exp[2] = 16'h0000;
        rd_idx[3] = 5'd31; rd_exp[3] = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            spin_rd_idx = rd_idx[i];
            #1 chk("spin_rd_word", 32'(spin_rd_word), 32'(rd_exp[i]));
        end
        spin_rd_idx = 5'd24;
        #1 chk("spin_rd_word_last", 32'(spin_rd_word), 32'h0000FF00);

        // Stable pattern with slow neuron: one sweep, converged.
        do_run("stable", 25'h1FFFFFF, M_COPY, 3, 1'b0, 1'b0, el);
        chk("stable_lit_sweeps", 32'(sweep_count), 32'd1);
        chk("stable_lit_conv", 32'(converged), 32'd1);
        chk("stable_lit_state", 32'(state_q), 32'h01FFFFFF);

        // Flip-then-settle: 2 sweeps, 100 cycles.
        do_run("flip", 25'h0, M_ONE, 0, 1'b0, 1'b0, el);
        chk("flip_lit_cycles", 32'(el), 32'd100);
        chk("flip_lit_sweeps", 32'(sweep_count), 32'd2);
        chk("flip_lit_state", 32'(state_q), 32'h01FFFFFF);

        // Oscillation: hits the sweep limit, even flips restore the pattern.
        do_run("osc", 25'h0A5A5A5, M_INV, 0, 1'b0, 1'b0, el);
        chk("osc_lit_sweeps", 32'(sweep_count), 32'd8);
        chk("osc_lit_conv", 32'(converged), 32'd0);
        chk("osc_lit_state", 32'(state_q), 32'h00A5A5A5);
        chk("osc_lit_cycles", 32'(el), 32'd400);

        // load+start together from DONE: run uses the new pattern.
        do_run("joint", 25'h1555555, M_COPY, 0, 1'b1, 1'b0, el);
        chk("joint_lit_state", 32'(state_q), 32'h01555555);
        chk("joint_lit_sweeps", 32'(sweep_count), 32'd1);

        // load/start while busy and stray acks in NEXT: same as undisturbed.
        stray_en = 1'b1;
        do_run("disturb", 25'h0F0F0F0, M_ONE, 0, 1'b0, 1'b1, el);
        stray_en = 1'b0;
        chk("disturb_lit_state", 32'(state_q), 32'h01FFFFFF);
        chk("disturb_lit_cycles", 32'(el), 32'd100);

        // Reset mid-sweep.
        resp_mode = M_COPY; resp_dly = 0; served = 0; wait_cnt = 0; exp_total = MAXSW * N;
        @(posedge clk); #1 load = 1'b1; start = 1'b1; pattern_in = 25'h1234567;
        @(posedge clk); #1 load = 1'b0; start = 1'b0; m_state = 25'h1234567;
        hit = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (eval_req && eval_idx == 5'd10) begin hit = 1'b1; break; end
        end
        chk("midrun_reached_idx10", 32'(hit), 32'd1);
        #1 chk_en = 1'b0; rst = 1'b0;
        #1;
        chk("mid_rst_state", 32'(state_q), 32'd0);
        chk("mid_rst_eval_req", 32'(eval_req), 32'd0);
        chk("mid_rst_eval_idx", 32'(eval_idx), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_conv", 32'(converged), 32'd0);
        chk("mid_rst_sweeps", 32'(sweep_count), 32'd0);
        @(negedge clk); #2 rst = 1'b1; m_state = '0; served = 0; chk_en = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("post_rst_eval_req", 32'(eval_req), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
